// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_unit
// Brief    : Resolves EX-stage branches/jumps from the ALU zero flag, owns the
//            program counter, redirects fetch and drives a counted flush that
//            squashes wrong-path instructions in the younger stages.
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2,
    parameter int          CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 ex_valid,
    input  logic [5:0]           ex_opcode,
    input  logic [31:0]          ex_pc,
    input  logic [31:0]          ex_imm,
    input  logic                 zero_flag,
    output logic [31:0]          pc_out,
    output logic                 redirect,
    output logic                 flush,
    output logic [CNT_WIDTH-1:0] taken_count
);

    localparam logic [5:0] c_OP_BEQ = 6'h04;
    localparam logic [5:0] c_OP_BNE = 6'h22;
    localparam logic [5:0] c_OP_J   = 6'h02;

    // Counter preload: flush stays high for this many cycles after the redirect one.
    localparam logic [2:0] c_FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    typedef enum logic [0:0] {
        S_RUN   = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [31:0]          r_pc;
    logic [31:0]          w_pc_nxt;
    logic                 r_redirect;
    logic                 w_redirect_nxt;
    logic                 r_flush;
    logic                 w_flush_nxt;
    logic [2:0]           r_fcnt;
    logic [2:0]           w_fcnt_nxt;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;

    logic [31:0] w_ex_pc4;
    logic [31:0] w_br_target;
    logic [31:0] w_j_target;
    logic [31:0] w_target;
    logic        w_is_j;
    logic        w_dec_taken;
    logic        w_take;

    // Decode: the ALU already inverted zero_flag for the BNE-style opcode.
    assign w_ex_pc4    = ex_pc + 32'd4;
    assign w_br_target = w_ex_pc4 + (ex_imm << 2);
    assign w_j_target  = {w_ex_pc4[31:28], ex_imm[25:0], 2'b00};
    assign w_is_j      = (ex_opcode == c_OP_J);
    assign w_dec_taken = w_is_j | (((ex_opcode == c_OP_BEQ) | (ex_opcode == c_OP_BNE)) & zero_flag);
    assign w_target    = w_is_j ? w_j_target : w_br_target;
    assign w_take      = ex_valid & (r_state == S_RUN) & w_dec_taken;

    // Next-state and next-output logic; a taken redirect always beats stall.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_redirect_nxt = 1'b0;
        w_flush_nxt    = 1'b0;
        w_fcnt_nxt     = r_fcnt;
        w_cnt_nxt      = r_cnt;
        case (r_state)
            S_RUN: begin
                if (w_take) begin
                    w_pc_nxt       = w_target;
                    w_redirect_nxt = 1'b1;
                    w_flush_nxt    = 1'b1;
                    w_fcnt_nxt     = c_FLUSH_INIT;
                    if (r_cnt != {CNT_WIDTH{1'b1}}) begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                    w_state_nxt    = (FLUSH_CYCLES > 1) ? S_FLUSH : S_RUN;
                end else if (!stall) begin
                    w_pc_nxt = r_pc + 32'd4;
                end
            end
            S_FLUSH: begin
                // EX contents are wrong-path here and are ignored entirely.
                if (!stall) begin
                    w_pc_nxt = r_pc + 32'd4;
                end
                if (r_fcnt == 3'd0) begin
                    w_flush_nxt = 1'b0;
                    w_state_nxt = S_RUN;
                end else begin
                    w_flush_nxt = 1'b1;
                    w_fcnt_nxt  = r_fcnt - 3'd1;
                end
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_RUN;
            r_pc       <= RESET_PC;
            r_redirect <= 1'b0;
            r_flush    <= 1'b0;
            r_fcnt     <= 3'd0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_redirect <= w_redirect_nxt;
            r_flush    <= w_flush_nxt;
            r_fcnt     <= w_fcnt_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

    assign pc_out      = r_pc;
    assign redirect    = r_redirect;
    assign flush       = r_flush;
    assign taken_count = r_cnt;

endmodule
`default_nettype wire

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Consumer side of the execute-stage ALU. Takes the ALU zero flag plus the EX-stage opcode, PC and immediate, and decides whether a branch or jump is taken.
- Owns the program counter and redirects fetch to the resolved target.
- On every redirect, drives a counted flush so the wrong-path instructions in the younger stages are squashed.

Parameters:
- RESET_PC, 32'h0000_0000, value loaded into pc_out on reset
- FLUSH_CYCLES, 2, number of cycles flush stays high after a redirect (legal range 1..7)
- CNT_WIDTH, 16, width of the taken-branch statistics counter

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- stall  input  1  hazard stall from decode; holds the PC when no redirect is pending
- ex_valid  input  1  EX stage holds a live instruction
- ex_opcode  input  6  opcode of the EX instruction
- ex_pc  input  32  PC of the EX instruction
- ex_imm  input  32  sign-extended immediate, or raw instruction bits [25:0] for J
- zero_flag  input  1  ALU flag; already inverted by the ALU for opcode 6'h22
- pc_out  output  32  current fetch address
- redirect  output  1  one-cycle pulse; pc_out was loaded with a branch/jump target this cycle
- flush  output  1  squash the IF/ID and ID/EX contents
- taken_count  output  CNT_WIDTH  saturating count of taken redirects

Behaviour:
- Reset (async, rst_n=0):
  - pc_out=RESET_PC, redirect=0, flush=0, taken_count=0, state=RUN, flush counter=0.
  - Release is synchronous to the next clk edge.
- Decode, evaluated combinationally each cycle from the EX inputs:
  - BEQ (6'h04) and BNE-style (6'h22): taken when zero_flag=1. The ALU has already inverted the flag for 6'h22, so this unit does not invert it.
  - Branch target = ex_pc + 4 + (ex_imm << 2), modulo 2^32.
  - J (6'h02): always taken. Target = {ex_pc+4 [31:28], ex_imm[25:0], 2'b00}.
  - Any other opcode: not taken.
- take = ex_valid & (state==RUN) & decoded-taken.
- State RUN:
  - take=1: next edge pc_out<=target, redirect<=1, flush<=1, counter<=FLUSH_CYCLES-1, taken_count increments, then go to FLUSH. If FLUSH_CYCLES=1, stay in RUN with flush high for exactly one cycle.
  - take has priority over stall. A redirect is never lost to a stall.
  - take=0 and stall=0: pc_out<=pc_out+4, wrapping 32'hFFFF_FFFC to 32'h0000_0000.
  - take=0 and stall=1: pc_out holds.
  - redirect<=0 and flush<=0 on every non-take edge in RUN.
- State FLUSH:
  - ex_valid, ex_opcode and zero_flag are ignored; those are wrong-path instructions.
  - flush stays 1 and redirect<=0.
  - pc_out advances by 4 unless stall=1.
  - The counter decrements every cycle, stall or not. At counter==0, the next edge sets flush<=0 and returns to RUN.
- Timing:
  - flush is high for exactly FLUSH_CYCLES consecutive cycles, starting the cycle redirect is high.
  - Latency from a taken branch in EX to pc_out=target is 1 clock edge.
- taken_count saturates at all-ones and never wraps.
- Reset asserted mid-FLUSH: flush drops immediately (asynchronously), pc_out=RESET_PC, state=RUN.
- No X propagation: with ex_valid=0, the opcode, imm and flag inputs are don't-care.

Test Plan:
1. Reset, then run free with stall=0, RESET_PC=0 → pc_out steps 0x0, 0x4, 0x8, 0xC on successive edges; flush=0, redirect=0.
2. Taken BEQ:
   - Stimulus: ex_valid=1, ex_opcode=6'h04, ex_pc=0x100, ex_imm=0x10, zero_flag=1.
   - Next edge: pc_out=0x144, redirect=1 for one cycle, flush=1 for 2 cycles, taken_count=1.
   - During those 2 cycles, a second taken BEQ presented on the EX inputs is ignored.
3. Opcode 6'h22 with zero_flag=0 → not taken, pc_out=prev+4. Same opcode with zero_flag=1, ex_pc=0x200, ex_imm=32'hFFFF_FFFE → pc_out=0x1FC.
4. Jump versus stall:
   - J with ex_pc=0x3000_0000, ex_imm=26'h0000040, stall=1 → pc_out=0x3000_0100 (redirect beats stall).
   - Then stall=1 in FLUSH → pc_out holds and flush still ends after 2 cycles.
5. Wrap: pc_out=0xFFFF_FFFC, no branch, stall=0 → pc_out=0x0000_0000.
6. Reset and saturation:
   - Assert rst_n=0 during the first flush cycle → flush=0 and pc_out=RESET_PC immediately, no clock needed.
   - With CNT_WIDTH=2, issue 5 taken J → taken_count stays at 3.
